// File: rtl/fp_multiplier_iter_if.sv
// Operand/result handshake bundle for the iterative floating-point multiplier.
// Carries operands a_in/b_in with valid_in/ready_out, and the product fpm_out
// with valid_out/ready_in plus the overflow/underflow/invalid result flags.
// The slave modport is the multiplier side; the master modport is the producer/consumer side.
interface fp_multiplier_iter_if #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23
);
    localparam int W = EXP_WIDTH + MANTISSA_WIDTH + 1;

    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         valid_in;
    logic         ready_out;
    logic [W-1:0] fpm_out;
    logic         valid_out;
    logic         ready_in;
    logic         overflow_out;
    logic         underflow_out;
    logic         invalid_out;

    modport slave (
        input  a_in, b_in, valid_in, ready_in,
        output ready_out, fpm_out, valid_out, overflow_out, underflow_out, invalid_out
    );

    modport master (
        output a_in, b_in, valid_in, ready_in,
        input  ready_out, fpm_out, valid_out, overflow_out, underflow_out, invalid_out
    );
endinterface

// File: rtl/fp_multiplier_iter.sv
// Iterative floating-point multiplier: shift-add significand product, round-to-nearest-even, no denormals.
// Latency: specials reach DONE on the accepting edge; normals take M+1 MULT cycles plus NORM and ROUND.
// Backpressure: one operation in flight; ready_out only in IDLE; DONE holds the result until ready_in.
// Ports: clk_in/rst_in (async active-high) plain; operands, result, flags and handshakes via bus (slave).
module fp_multiplier_iter #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    fp_multiplier_iter_if.slave   bus
);
    localparam int M  = MANTISSA_WIDTH;
    localparam int E  = EXP_WIDTH;
    localparam int W  = E + M + 1;
    localparam int PW = 2 * M + 2;          // full significand product width
    localparam int XW = E + 2;              // signed working exponent width
    localparam int CW = $clog2(M + 1);      // multiplier bit counter width

    localparam logic [E-1:0]           EXP_ONES = {E{1'b1}};
    localparam logic [XW-1:0]          BIAS_X   = XW'((2 ** (E - 1)) - 1);
    localparam logic signed [XW-1:0]   ONE_X    = 1;
    localparam logic signed [XW-1:0]   EXP_MAX  = {2'b00, EXP_ONES};
    localparam logic [CW-1:0]          CNT_LAST = CW'(M);
    localparam logic [W-1:0]           QNAN     = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t state, state_nxt;

    // Operand field decode, only meaningful in the accepting cycle.
    logic          a_sign, b_sign;
    logic [E-1:0]  a_exp, b_exp;
    logic [M-1:0]  a_frac, b_frac;
    logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic          is_special, is_invalid, is_inf;
    logic [W-1:0]  special_res;
    logic [XW-1:0] exp_calc;
    logic          accept;

    assign a_sign = bus.a_in[W-1];
    assign b_sign = bus.b_in[W-1];
    assign a_exp  = bus.a_in[W-2:M];
    assign b_exp  = bus.b_in[W-2:M];
    assign a_frac = bus.a_in[M-1:0];
    assign b_frac = bus.b_in[M-1:0];

    // Zero exponent flushes any fraction to zero.
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);

    assign is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    assign is_invalid = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    assign is_inf     = a_inf | b_inf;

    always_comb begin
        special_res = {a_sign ^ b_sign, {(E+M){1'b0}}};
        if (is_invalid) begin
            special_res = QNAN;
        end else if (is_inf) begin
            special_res = {a_sign ^ b_sign, EXP_ONES, {M{1'b0}}};
        end
    end

    // Both exponents are at least 1 here, so the XW-bit result never wraps.
    assign exp_calc = {2'b00, a_exp} + {2'b00, b_exp} - BIAS_X;
    assign accept   = (state == IDLE) && bus.valid_in;

    // Datapath registers.
    logic                  sign_r;
    logic signed [XW-1:0]  exp_r;
    logic [PW-1:0]         mcand_sh;
    logic [M:0]            mplier;
    logic [PW-1:0]         prod;
    logic [CW-1:0]         cnt;
    logic [M-1:0]          mant_r;
    logic                  guard_r;
    logic                  sticky_r;
    logic [W-1:0]          fpm_r;
    logic                  ovf_r, unf_r, inv_r;

    // Rounding and final range check, consumed on the ROUND edge.
    logic                  round_up;
    logic [M:0]            mant_sum;
    logic signed [XW-1:0]  exp_fin;
    logic [W-1:0]          round_res;
    logic                  round_ovf, round_unf;

    always_comb begin
        round_up  = guard_r & (sticky_r | mant_r[0]);
        mant_sum  = {1'b0, mant_r} + {{M{1'b0}}, round_up};
        // A carry out leaves mant_sum[M-1:0] all zero, i.e. exactly 1.0.
        exp_fin   = mant_sum[M] ? (exp_r + ONE_X) : exp_r;
        round_ovf = 1'b0;
        round_unf = 1'b0;
        round_res = {sign_r, exp_fin[E-1:0], mant_sum[M-1:0]};
        if (exp_fin >= EXP_MAX) begin
            round_ovf = 1'b1;
            round_res = {sign_r, EXP_ONES, {M{1'b0}}};
        end else if (exp_fin <= 0) begin
            round_unf = 1'b1;
            round_res = {sign_r, {(E+M){1'b0}}};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.valid_in) begin
                    state_nxt = is_special ? DONE : MULT;
                end
            end
            MULT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = NORM;
                end
            end
            NORM:  state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE: begin
                if (bus.ready_in) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sign_r   <= 1'b0;
            exp_r    <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            prod     <= '0;
            cnt      <= '0;
            mant_r   <= '0;
            guard_r  <= 1'b0;
            sticky_r <= 1'b0;
            fpm_r    <= '0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            inv_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_r   <= a_sign ^ b_sign;
                        exp_r    <= exp_calc;
                        mcand_sh <= {{(M+1){1'b0}}, 1'b1, a_frac};
                        mplier   <= {1'b1, b_frac};
                        prod     <= '0;
                        cnt      <= '0;
                        if (is_special) begin
                            fpm_r <= special_res;
                            ovf_r <= 1'b0;
                            unf_r <= 1'b0;
                            inv_r <= is_invalid;
                        end
                    end
                end
                MULT: begin
                    // One multiplier bit per cycle, LSB first, against a left-shifting multiplicand.
                    if (mplier[0]) begin
                        prod <= prod + mcand_sh;
                    end
                    mcand_sh <= mcand_sh << 1;
                    mplier   <= mplier >> 1;
                    cnt      <= cnt + 1'b1;
                end
                NORM: begin
                    // Product of two [1,2) significands lies in [1,4); MSB set means [2,4).
                    if (prod[PW-1]) begin
                        mant_r   <= prod[PW-2:M+1];
                        guard_r  <= prod[M];
                        sticky_r <= |prod[M-1:0];
                        exp_r    <= exp_r + ONE_X;
                    end else begin
                        mant_r   <= prod[PW-3:M];
                        guard_r  <= prod[M-1];
                        sticky_r <= |prod[M-2:0];
                    end
                end
                ROUND: begin
                    fpm_r <= round_res;
                    ovf_r <= round_ovf;
                    unf_r <= round_unf;
                    inv_r <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready_out     = (state == IDLE) && !rst_in;
    assign bus.valid_out     = (state == DONE);
    assign bus.fpm_out       = fpm_r;
    assign bus.overflow_out  = ovf_r;
    assign bus.underflow_out = unf_r;
    assign bus.invalid_out   = inv_r;
endmodule

// File: tb/tb_fp_multiplier_iter.sv
module tb_fp_multiplier_iter;
    logic clk_in = 1'b0;
    logic rst_in;

    fp_multiplier_iter_if #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) bus ();

    fp_multiplier_iter #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flg;   // {overflow, underflow, invalid}
        int          lat;   // edges counted including the accepting edge
    } vec_t;

    vec_t vecs[18];
    int   checks_total  = 0;
    int   checks_passed = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks_total++;
        if (got === want) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    function automatic logic [2:0] flags_now();
        return {bus.overflow_out, bus.underflow_out, bus.invalid_out};
    endfunction

    // Issues one operation and waits for valid_out; leaves DONE when ready_in is high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [2:0] flg, output int edges);
        int n;
        n = 0;
        while (!bus.ready_out && n < 200) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (!bus.ready_out) check("ready_timeout", {63'd0, bus.ready_out}, 64'd1);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.valid_in = 1'b1;
        @(posedge clk_in); #1;
        bus.valid_in = 1'b0;
        bus.a_in     = ~a;  // later operand changes must be ignored
        bus.b_in     = ~b;
        edges = 1;
        while (!bus.valid_out && edges < 200) begin
            @(posedge clk_in); #1;
            edges++;
        end
        res = bus.fpm_out;
        flg = flags_now();
        if (bus.ready_in) begin
            @(posedge clk_in); #1;
            check("leave_done", {62'd0, bus.valid_out, bus.ready_out}, 64'd1);
        end
    endtask

    logic [31:0] res;
    logic [2:0]  flg;
    int          edges;
    logic        hold_vld, hold_res, hold_rdy;

    initial begin
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 27};
        vecs[1]  = '{32'h3F800001, 32'h40400000, 32'h40400002, 3'b000, 27};
        vecs[2]  = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 3'b000, 27};
        vecs[3]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b100, 27};
        vecs[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b010, 27};
        vecs[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 1};
        vecs[6]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1};
        vecs[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001, 1};
        vecs[8]  = '{32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 1};
        vecs[9]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 27};
        vecs[10] = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 3'b000, 27};
        vecs[11] = '{32'h20000000, 32'h20000000, 32'h00800000, 3'b000, 27};
        vecs[12] = '{32'hA0000000, 32'h1F800000, 32'h80000000, 3'b010, 27};
        vecs[13] = '{32'h5F800000, 32'h5F000000, 32'h7F000000, 3'b000, 27};
        vecs[14] = '{32'h5F800000, 32'h5F800000, 32'h7F800000, 3'b100, 27};
        vecs[15] = '{32'h00400000, 32'hC0000000, 32'h80000000, 3'b000, 1};
        vecs[16] = '{32'h7F800000, 32'hFF800000, 32'hFF800000, 3'b000, 1};
        vecs[17] = '{32'hFF800000, 32'h00000000, 32'h7FC00000, 3'b001, 1};

        rst_in       = 1'b1;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        #3;
        check("reset_fpm",   {32'd0, bus.fpm_out}, 64'd0);
        check("reset_vld",   {63'd0, bus.valid_out}, 64'd0);
        check("reset_rdy",   {63'd0, bus.ready_out}, 64'd0);
        check("reset_flags", {61'd0, flags_now()}, 64'd0);
        #19 rst_in = 1'b0;
        #1;
        check("rdy_after_reset", {63'd0, bus.ready_out}, 64'd1);

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].a, vecs[i].b, res, flg, edges);
            check($sformatf("v%0d_res", i), {32'd0, res}, {32'd0, vecs[i].res});
            check($sformatf("v%0d_flags", i), {61'd0, flg}, {61'd0, vecs[i].flg});
            check($sformatf("v%0d_latency", i), 64'(edges), 64'(vecs[i].lat));
        end

        // Backpressure: result and valid held, new operands ignored while DONE.
        bus.ready_in = 1'b0;
        run_op(32'h3FC00000, 32'h40000000, res, flg, edges);
        check("bp_res", {32'd0, res}, 64'h40400000);
        hold_vld = 1'b1;
        hold_res = 1'b1;
        hold_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.valid_in = c[0];
            bus.a_in     = 32'h7F800000;
            bus.b_in     = 32'h00000000;
            @(posedge clk_in); #1;
            if (bus.valid_out !== 1'b1)          hold_vld = 1'b0;
            if (bus.fpm_out !== 32'h40400000)    hold_res = 1'b0;
            if (bus.ready_out !== 1'b0)          hold_rdy = 1'b0;
        end
        check("bp_hold_vld", {63'd0, hold_vld}, 64'd1);
        check("bp_hold_res", {63'd0, hold_res}, 64'd1);
        check("bp_hold_rdy", {63'd0, hold_rdy}, 64'd1);
        // Release with valid_in high: must return to IDLE without accepting.
        bus.valid_in = 1'b1;
        bus.ready_in = 1'b1;
        @(posedge clk_in); #1;
        bus.valid_in = 1'b0;
        check("bp_release_vld", {63'd0, bus.valid_out}, 64'd0);
        check("bp_release_rdy", {63'd0, bus.ready_out}, 64'd1);
        check("bp_release_res", {32'd0, bus.fpm_out}, 64'h40400000);
        check("bp_release_flags", {61'd0, flags_now()}, 64'd0);

        // Reset asserted between edges in the tenth MULT cycle.
        bus.a_in     = 32'h3F800001;
        bus.b_in     = 32'h40400000;
        bus.valid_in = 1'b1;
        @(posedge clk_in); #1;
        bus.valid_in = 1'b0;
        repeat (10) @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        check("midrst_fpm", {32'd0, bus.fpm_out}, 64'd0);
        check("midrst_vld", {63'd0, bus.valid_out}, 64'd0);
        check("midrst_rdy", {63'd0, bus.ready_out}, 64'd0);
        @(posedge clk_in);
        #3 rst_in = 1'b0;
        #1;
        check("midrst_rdy_release", {63'd0, bus.ready_out}, 64'd1);
        run_op(32'h3FC00000, 32'h40000000, res, flg, edges);
        check("midrst_res", {32'd0, res}, 64'h40400000);
        check("midrst_flags", {61'd0, flg}, 64'd0);
        check("midrst_latency", 64'(edges), 64'd27);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/fp_multiplier_iter.md
FP_MULTIPLIER_ITER -- requirements
Module: fp_multiplier_iter

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, stored fraction width (M); word width W = EXP_WIDTH+MANTISSA_WIDTH+1.
REQ-003 SHALL have port clk_in input 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in input 1, asynchronous active-high reset.
REQ-005 SHALL have ports a_in, b_in input W, operands {sign, biased exp, fraction}.
REQ-006 SHALL have port valid_in input 1, operands valid.
REQ-007 SHALL have port ready_out output 1, block can accept operands.
REQ-008 SHALL have port fpm_out output W, product.
REQ-009 SHALL have port valid_out output 1, fpm_out and flags valid.
REQ-010 SHALL have port ready_in input 1, consumer accepts the result.
REQ-011 SHALL have ports overflow_out, underflow_out, invalid_out output 1, result flags.

Function
REQ-012 SHALL use FSM states IDLE, MULT, NORM, ROUND, DONE.
REQ-013 SHALL drive ready_out=1 only in IDLE with rst_in low; valid_out=1 only in DONE.
REQ-014 SHALL accept operands on a rising edge with IDLE, valid_in=1; a_in/b_in registered that edge, later changes ignored.
REQ-015 SHALL treat exp=0 as zero (denormals flushed, fraction ignored), exp=all-ones/fraction=0 as infinity, exp=all-ones/fraction!=0 as NaN.
REQ-016 SHALL, for special operands, go IDLE->DONE on the accepting edge (result visible 1 edge later): any NaN or inf*zero -> 0 | all-ones | 1 followed by M-1 zeros (quiet NaN, sign 0) with invalid_out=1; else any inf -> signed inf; else any zero -> signed zero; no other flag set.
REQ-017 SHALL, for normal operands, go IDLE->MULT and compute the (M+1)x(M+1) significand product (hidden bit 1) by shift-add, one multiplier bit per cycle, exactly M+1 cycles in MULT, then NORM, ROUND, DONE one cycle each: valid_out first high after M+3 rising edges following the accepting edge (27 at defaults).
REQ-018 SHALL compute exponent as ea+eb-(2^(EXP_WIDTH-1)-1) in a signed EXP_WIDTH+2-bit register, no wrap-around.
REQ-019 SHALL in NORM shift the 2M+2-bit product right by 1 and increment exponent when its MSB is 1; keep guard bit and sticky OR of all lower bits.
REQ-020 SHALL in ROUND apply round-to-nearest-even; a mantissa carry-out renormalises to 1.0 and increments exponent.
REQ-021 SHALL, if final exponent >= all-ones, output signed infinity, overflow_out=1.
REQ-022 SHALL, if final exponent <= 0, output signed zero, underflow_out=1 (no denormal output).
REQ-023 SHALL set result sign to sign(a) XOR sign(b) for all non-NaN results.
REQ-024 SHALL hold fpm_out, flags and valid_out stable in DONE while ready_in=0.
REQ-025 SHALL go DONE->IDLE on an edge with ready_in=1; valid_out falls, fpm_out/flags hold their last value until the next result; no acceptance in that same edge.
REQ-026 SHALL ignore valid_in outside IDLE.

Reset
REQ-027 SHALL, while rst_in=1 (async, any state incl. mid-MULT), force state IDLE, fpm_out=0, valid_out=0, all flags 0, ready_out=0, internal product/counter cleared; in-flight operation discarded.
REQ-028 SHALL raise ready_out combinationally once rst_in falls.

Verification
REQ-029 0x3FC00000 * 0x40000000 (1.5*2.0), ready_in=1 -> fpm_out=0x40400000 exactly 27 edges after acceptance, all flags 0.
REQ-030 0x3F800001 * 0x40400000 (tie) -> 0x40400002 (ties-to-even); 0xBF800000 * 0x3F800000 -> 0xBF800000.
REQ-031 0x7F7FFFFF * 0x40000000 -> 0x7F800000, overflow_out=1; 0x00800000 * 0x00800000 -> 0x00000000, underflow_out=1.
REQ-032 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid_out=1, valid_out 1 edge after acceptance; 0xFF800000 * 0x40000000 -> 0xFF800000, no flags.
REQ-033 Hold ready_in=0 for 10 cycles in DONE -> valid_out and fpm_out unchanged, ready_out=0, valid_in pulses ignored; release -> IDLE next edge.
REQ-034 Assert rst_in mid-MULT (cycle 10) between edges -> outputs 0 immediately; after release new operands yield the correct result with full 27-edge latency.
